// File: rtl/lifo_pop_streamer.sv
// lifo_pop_streamer: read-side controller for the lifo stack.
// Pops a burst of entries on start and streams them newest-first on a
// valid/ready interface, tagging the final beat. A 2-entry output buffer
// absorbs the stack's one-cycle read latency so backpressure never drops data.
// Optional build macro: LIFO_POP_PARITY_EN adds m_parity (even parity of m_data).
module lifo_pop_streamer #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             lifo_empty,
    input  logic [WIDTH-1:0] lifo_dout,
    output logic             lifo_read_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             short,
`ifdef LIFO_POP_PARITY_EN
    output logic             m_parity,
`endif
    output logic [CNT_W-1:0] beat_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Drain mode never pops more than the stack can hold, so issued cannot wrap.
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   target_reg, target_next;
    logic [CNT_W-1:0]   issued_reg, issued_next;
    logic [CNT_W-1:0]   beat_count_reg, beat_count_next;
    logic               done_reg, done_next;
    logic               short_reg, short_next;
    logic               inflight_reg;
    logic [1:0]         occ_reg, occ_next;

    // Output buffer: entry 0 is the head presented on the stream.
    logic [1:0][WIDTH-1:0] buf_data_reg, buf_data_next;
    logic [1:0]            buf_last_reg, buf_last_next;
`ifdef LIFO_POP_PARITY_EN
    logic [1:0]            buf_par_reg, buf_par_next;
    logic                  cap_par;
`endif

    logic       read_en;
    logic       pop;
    logic       push;
    logic [1:0] occ_mid;
    logic       room_ok;
    logic       count_ok;
    logic       cap_last;
    logic [1:0] load_sel;

    assign pop      = m_valid & m_ready;
    assign push     = inflight_reg;
    assign occ_mid  = occ_reg - {1'b0, pop};
    // Occupancy next cycle, counting the read already on its way back.
    assign occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    assign room_ok  = (occ_next < 2'd2);
    assign count_ok = (target_reg == '0) ? (issued_reg < DEPTH_CNT)
                                         : (issued_reg < target_reg);
    // issued_reg at capture time equals the ordinal of the entry being captured.
    assign cap_last = ((target_reg != '0) && (issued_reg == target_reg)) || lifo_empty;
`ifdef LIFO_POP_PARITY_EN
    assign cap_par  = ^lifo_dout;
`endif

    // Per-entry next values: load the returning read, or shift toward the head on a pop.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            assign load_sel[gi] = push && (occ_mid == 2'(gi));
            if (gi == 0) begin : g_head
                assign buf_data_next[gi] = load_sel[gi] ? lifo_dout
                                         : (pop ? buf_data_reg[1] : buf_data_reg[0]);
                assign buf_last_next[gi] = load_sel[gi] ? cap_last
                                         : (pop ? buf_last_reg[1] : buf_last_reg[0]);
`ifdef LIFO_POP_PARITY_EN
                assign buf_par_next[gi]  = load_sel[gi] ? cap_par
                                         : (pop ? buf_par_reg[1] : buf_par_reg[0]);
`endif
            end else begin : g_tail
                assign buf_data_next[gi] = load_sel[gi] ? lifo_dout : buf_data_reg[gi];
                assign buf_last_next[gi] = load_sel[gi] ? cap_last  : buf_last_reg[gi];
`ifdef LIFO_POP_PARITY_EN
                assign buf_par_next[gi]  = load_sel[gi] ? cap_par   : buf_par_reg[gi];
`endif
            end
        end
    endgenerate

    // Next-state, read issue and burst bookkeeping.
    always_comb begin
        state_next      = state_reg;
        target_next     = target_reg;
        issued_next     = issued_reg;
        beat_count_next = beat_count_reg + {{(CNT_W-1){1'b0}}, pop};
        short_next      = short_reg;
        done_next       = 1'b0;
        read_en         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    target_next     = burst_len;
                    issued_next     = '0;
                    beat_count_next = '0;
                    short_next      = 1'b0;
                    state_next      = lifo_empty ? S_FLUSH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                read_en = !lifo_empty && count_ok && room_ok;
                if (read_en) begin
                    issued_next = issued_reg + CNT_W'(1);
                end else if (lifo_empty || !count_ok) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!inflight_reg && (occ_reg == 2'd0)) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                    short_next = (target_reg != '0) && (beat_count_reg < target_reg);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            target_reg     <= '0;
            issued_reg     <= '0;
            beat_count_reg <= '0;
            done_reg       <= 1'b0;
            short_reg      <= 1'b0;
            inflight_reg   <= 1'b0;
            occ_reg        <= 2'd0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            issued_reg     <= issued_next;
            beat_count_reg <= beat_count_next;
            done_reg       <= done_next;
            short_reg      <= short_next;
            inflight_reg   <= read_en;
            occ_reg        <= occ_next;
        end
    end

    // Output buffer storage; cleared on reset so in-flight data is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_reg <= '0;
            buf_last_reg <= '0;
`ifdef LIFO_POP_PARITY_EN
            buf_par_reg  <= '0;
`endif
        end else begin
            buf_data_reg <= buf_data_next;
            buf_last_reg <= buf_last_next;
`ifdef LIFO_POP_PARITY_EN
            buf_par_reg  <= buf_par_next;
`endif
        end
    end

    assign lifo_read_en = read_en;
    assign m_valid      = (occ_reg != 2'd0);
    assign m_data       = buf_data_reg[0];
    assign m_last       = m_valid & buf_last_reg[0];
    assign busy         = (state_reg != S_IDLE);
    assign done         = done_reg;
    assign short        = short_reg;
    assign beat_count   = beat_count_reg;
`ifdef LIFO_POP_PARITY_EN
    assign m_parity     = buf_par_reg[0];
`endif

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Directed testbench for lifo_pop_streamer with a behavioural lifo model.
module tb_lifo_pop_streamer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             lifo_empty;
    logic [WIDTH-1:0] lifo_dout;
    logic             lifo_read_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic             short_flag;
    logic [CNT_W-1:0] beat_count;
`ifdef LIFO_POP_PARITY_EN
    logic             m_parity;
`endif

    lifo_pop_streamer #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .burst_len   (burst_len),
        .lifo_empty  (lifo_empty),
        .lifo_dout   (lifo_dout),
        .lifo_read_en(lifo_read_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .short       (short_flag),
`ifdef LIFO_POP_PARITY_EN
        .m_parity    (m_parity),
`endif
        .beat_count  (beat_count)
    );

    always #5 clk = ~clk;

    // Behavioural lifo: registered dout, empty reflects post-pop count.
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             lifo_clr;
    logic [WIDTH-1:0] stk [0:DEPTH-1];
    logic [4:0]       lcnt;

    always @(posedge clk) begin
        if (lifo_clr) begin
            lcnt      <= 5'd0;
            lifo_dout <= '0;
        end else if (wr_en && lcnt < 5'(DEPTH)) begin
            stk[lcnt[3:0]] <= wr_data;
            lcnt           <= lcnt + 5'd1;
        end else if (lifo_read_en && lcnt != 5'd0) begin
            lifo_dout <= stk[4'(lcnt - 5'd1)];
            lcnt      <= lcnt - 5'd1;
        end
    end
    assign lifo_empty = (lcnt == 5'd0);

    // Monitor: stream beats, pops and done pulses sampled on the falling edge.
    logic [WIDTH-1:0] beat_q [$];
    logic             last_q [$];
    int               cyc_q  [$];
    int               cyc       = 0;
    int               pops      = 0;
    int               done_seen = 0;
    int               done_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                cyc_q.push_back(cyc);
            end
            if (lifo_read_en && !lifo_empty) pops <= pops + 1;
            if (done) begin
                done_seen <= done_seen + 1;
                done_cyc  <= cyc;
            end
        end
    end

    int               total = 0;
    int               bad   = 0;
    int               done0;
    int               pops0;
    int               start_cyc;
    int               snap;
    logic [WIDTH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic clear_lifo();
        lifo_clr = 1'b1;
        tick();
        lifo_clr = 1'b0;
    endtask

    task automatic do_start(input int len);
        beat_q.delete();
        last_q.delete();
        cyc_q.delete();
        done0     = done_seen;
        pops0     = pops;
        burst_len = CNT_W'(len);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_seen == done0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done_seen - done0), 32'd1);
        $display("burst %s: beats=%0d beat_count=%0d short=%0b", tag, beat_q.size(), beat_count, short_flag);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_nbeats"}, 32'(beat_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(beat_q[i]), 32'(exp_q[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b1;
        burst_len = '0;
        m_ready   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        lifo_clr  = 1'b1;

        // 1: reset held with start high; one entry present must not be popped
        tick();
        lifo_clr = 1'b0;
        push(8'h55);
        tick();
        tick();
        check("t1_m_valid", 32'(m_valid), 32'd0);
        check("t1_read_en", 32'(lifo_read_en), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        check("t1_beat_count", 32'(beat_count), 32'd0);
        check("t1_short", 32'(short_flag), 32'd0);
        check("t1_m_last", 32'(m_last), 32'd0);
        check("t1_no_pop", 32'(lcnt), 32'd1);
        start = 1'b0;
        rst   = 1'b1;
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);

        // 2: drain-all burst of three entries at full rate
        clear_lifo();
        push(8'h03);
        push(8'h07);
        push(8'h09);
        m_ready = 1'b1;
        do_start(0);
        wait_done("t2");
        exp_q.delete();
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        check_beats("t2");
        for (int i = 1; i < cyc_q.size(); i++)
            check($sformatf("t2_consec%0d", i), 32'(cyc_q[i] - cyc_q[0]), 32'(i));
        check("t2_short", 32'(short_flag), 32'd0);
        check("t2_beat_count", 32'(beat_count), 32'd3);
        check("t2_empty", 32'(lifo_empty), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // 3: full stack, burst of 2
        clear_lifo();
        for (int i = 0; i < 16; i++) push(8'(i));
        do_start(2);
        wait_done("t3");
        exp_q.delete();
        exp_q.push_back(8'd15);
        exp_q.push_back(8'd14);
        check_beats("t3");
        check("t3_empty", 32'(lifo_empty), 32'd0);
        check("t3_left", 32'(lcnt), 32'd14);
        check("t3_pops", 32'(pops - pops0), 32'd2);
        check("t3_short", 32'(short_flag), 32'd0);
        check("t3_beat_count", 32'(beat_count), 32'd2);

        // 4: full stack, drain-all under 5 cycles of backpressure; a start while busy is ignored
        clear_lifo();
        for (int i = 0; i < 16; i++) push(8'(i));
        m_ready = 1'b0;
        do_start(0);
        for (int n = 0; n < 50 && !m_valid; n++) tick();
        check("t4_valid", 32'(m_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_hold%0d", k), 32'(m_data), 32'd15);
            start     = (k == 1);
            burst_len = 5'd3;
            tick();
        end
        start = 1'b0;
        check("t4_stall_pops_le2", 32'((pops - pops0) <= 2), 32'd1);
        m_ready = 1'b1;
        wait_done("t4");
        exp_q.delete();
        for (int i = 15; i >= 0; i--) exp_q.push_back(8'(i));
        check_beats("t4");
        check("t4_pops", 32'(pops - pops0), 32'd16);
        check("t4_short", 32'(short_flag), 32'd0);
        check("t4_beat_count", 32'(beat_count), 32'd16);

        // 5: burst longer than contents, then zero-beat burst on empty stack
        clear_lifo();
        push(8'hA5);
        push(8'h3C);
        do_start(5);
        wait_done("t5");
        exp_q.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hA5);
        check_beats("t5");
        check("t5_short", 32'(short_flag), 32'd1);
        check("t5_beat_count", 32'(beat_count), 32'd2);
        check("t5_empty", 32'(lifo_empty), 32'd1);
        do_start(5);
        wait_done("t5b");
        check("t5b_nbeats", 32'(beat_q.size()), 32'd0);
        check("t5b_done_lat", 32'(done_cyc - start_cyc), 32'd2);
        check("t5b_short", 32'(short_flag), 32'd1);
        check("t5b_beat_count", 32'(beat_count), 32'd0);

        // 6: asynchronous reset mid-burst, then a fresh single-beat burst
        clear_lifo();
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        m_ready = 1'b1;
        do_start(0);
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("t6_busy_drop", 32'(busy), 32'd0);
        check("t6_valid_drop", 32'(m_valid), 32'd0);
        check("t6_read_en_drop", 32'(lifo_read_en), 32'd0);
        tick();
        snap = int'(lcnt);
        check("t6_left", 32'(lcnt), 32'd6);
        #4;
        rst = 1'b1;
        tick();
        do_start(1);
        wait_done("t6");
        exp_q.delete();
        exp_q.push_back(8'h40 + 8'(snap - 1));
        check_beats("t6");
        check("t6_short", 32'(short_flag), 32'd0);
        check("t6_beat_count", 32'(beat_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
